// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the instruction cache responder.
package icache_pkg;

   localparam int unsigned CACHELINE_SIZE = 512;
   localparam int unsigned XLEN           = 64;
   localparam int unsigned DEF_SETS       = 64;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      MISS_REQ,
      MISS_WAIT,
      RESP
   } icache_state_t;

   // Byte-offset bits inside one line.
   function automatic int unsigned ofs_bits(input int unsigned line_bits);
      return $clog2(line_bits / 8);
   endfunction

   // Index bits selecting one of the sets.
   function automatic int unsigned idx_bits(input int unsigned sets);
      return $clog2(sets);
   endfunction

   // Whatever is left above offset and index is the tag.
   function automatic int unsigned tag_bits(input int unsigned addr_bits,
                                            input int unsigned line_bits,
                                            input int unsigned sets);
      return addr_bits - ofs_bits(line_bits) - idx_bits(sets);
   endfunction

   localparam int unsigned DEF_TAG_BITS = tag_bits(XLEN, CACHELINE_SIZE, DEF_SETS);

   typedef logic [DEF_TAG_BITS-1:0] icache_tag_t;

endpackage

// File: rtl/core2icache_if.sv
// Fetch-side handshake between the core (master) and the instruction cache (slave).
interface core2icache_if
   import icache_pkg::*;
#(
   parameter int unsigned ADDR_BITS = XLEN,
   parameter int unsigned LINE_BITS = CACHELINE_SIZE
);

   logic                 req;
   logic                 gnt;
   logic [ADDR_BITS-1:0] addr;
   logic                 rsp;
   logic [LINE_BITS-1:0] rdata;

   modport m (output req, output addr, input gnt, input rsp, input rdata);
   modport s (input req, input addr, output gnt, output rsp, output rdata);

endinterface

// File: rtl/icache_tag_data_array.sv
// Valid/tag/data storage for a direct-mapped cache: one combinational read
// port, one write port and a flash invalidate of every valid bit.
module icache_tag_data_array
   import icache_pkg::*;
#(
   parameter int unsigned SETS      = DEF_SETS,
   parameter int unsigned TAG_BITS  = DEF_TAG_BITS,
   parameter int unsigned LINE_BITS = CACHELINE_SIZE,
   localparam int unsigned IDX      = idx_bits(SETS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flash_inv,
   input  logic [IDX-1:0]       rd_index,
   output logic                 rd_valid,
   output logic [TAG_BITS-1:0]  rd_tag,
   output logic [LINE_BITS-1:0] rd_data,
   input  logic                 wr_en,
   input  logic [IDX-1:0]       wr_index,
   input  logic [TAG_BITS-1:0]  wr_tag,
   input  logic [LINE_BITS-1:0] wr_data
);

   logic [SETS-1:0]      valid;
   logic [TAG_BITS-1:0]  tag_mem  [SETS];
   logic [LINE_BITS-1:0] data_mem [SETS];

   // Valid bits: cleared by reset or flash invalidate, set on install.
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid <= '0;
      end else if (flash_inv) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_index] <= 1'b1;
      end
   end

   // Tag and data storage written on install.
   // NOTE: tag/data arrays carry no reset; a cleared valid bit already hides their contents.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[wr_index]  <= wr_tag;
         data_mem[wr_index] <= wr_data;
      end
   end

   assign rd_valid = valid[rd_index];
   assign rd_tag   = tag_mem[rd_index];
   assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache: answers one line-granular fetch
// at a time, refilling misses from next-level memory over a req/gnt/rsp port.
module icache_responder
   import icache_pkg::*;
#(
   parameter int unsigned SETS      = DEF_SETS,
   parameter int unsigned LINE_BITS = CACHELINE_SIZE,
   parameter int unsigned ADDR_BITS = XLEN
) (
   input  logic                 clk,
   input  logic                 rst,
   core2icache_if.s             core,
   input  logic                 flush,
   output logic                 mem_req,
   input  logic                 mem_gnt,
   output logic [ADDR_BITS-1:0] mem_addr,
   input  logic                 mem_rsp,
   input  logic [LINE_BITS-1:0] mem_rdata
);

   localparam int unsigned OFS = ofs_bits(LINE_BITS);
   localparam int unsigned IDX = idx_bits(SETS);
   localparam int unsigned TAG = tag_bits(ADDR_BITS, LINE_BITS, SETS);

   localparam logic [ADDR_BITS-1:0] LINE_MASK = {{TAG+IDX{1'b1}}, {OFS{1'b0}}};

   icache_state_t        state;
   icache_state_t        state_nxt;

   logic [ADDR_BITS-1:0] addr_q;
   logic [LINE_BITS-1:0] line_q;
   logic [LINE_BITS-1:0] rdata_q;
   logic                 flush_pend;

   logic [IDX-1:0]       index;
   logic [TAG-1:0]       tag;
   logic                 rd_valid;
   logic [TAG-1:0]       rd_tag;
   logic [LINE_BITS-1:0] rd_data;
   logic                 hit;

   logic                 core_gnt;
   logic                 core_rsp;
   logic [LINE_BITS-1:0] core_rdata;
   logic                 accept;
   logic                 capture;
   logic                 install;

   assign index = addr_q[OFS+IDX-1:OFS];
   assign tag   = addr_q[ADDR_BITS-1:OFS+IDX];
   assign hit   = rd_valid && (rd_tag == tag);

   icache_tag_data_array #(
      .SETS      (SETS),
      .TAG_BITS  (TAG),
      .LINE_BITS (LINE_BITS)
   ) u_array (
      .clk       (clk),
      .rst       (rst),
      .flash_inv (flush),
      .rd_index  (index),
      .rd_valid  (rd_valid),
      .rd_tag    (rd_tag),
      .rd_data   (rd_data),
      .wr_en     (install),
      .wr_index  (index),
      .wr_tag    (tag),
      .wr_data   (mem_rdata)
   );

   // State register; reset drops any in-flight refill straight back to IDLE.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and output decode.
   // NOTE: every output gets a default before the case so no path can infer a latch.
   always_comb begin
      state_nxt  = state;
      core_gnt   = 1'b0;
      core_rsp   = 1'b0;
      core_rdata = rdata_q;
      mem_req    = 1'b0;
      accept     = 1'b0;
      capture    = 1'b0;
      install    = 1'b0;
      unique case (state)
         IDLE: begin
            core_gnt = rst && !flush;
            if (core.req && core_gnt) begin
               accept    = 1'b1;
               state_nxt = LOOKUP;
            end
         end
         LOOKUP: begin
            if (hit) begin
               core_rsp   = 1'b1;
               core_rdata = rd_data;
               state_nxt  = IDLE;
            end else begin
               state_nxt  = MISS_REQ;
            end
         end
         MISS_REQ: begin
            mem_req = 1'b1;
            if (mem_gnt) begin
               state_nxt = MISS_WAIT;
            end
         end
         MISS_WAIT: begin
            if (mem_rsp) begin
               capture   = 1'b1;
               install   = !flush && !flush_pend;
               state_nxt = RESP;
            end
         end
         RESP: begin
            core_rsp   = 1'b1;
            core_rdata = line_q;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Latched request address, refill line, last returned line and flush-pending flag.
   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         addr_q     <= '0;
         line_q     <= '0;
         rdata_q    <= '0;
         flush_pend <= 1'b0;
      end else begin
         if (accept) begin
            addr_q <= core.addr;
         end
         if (capture) begin
            line_q <= mem_rdata;
         end
         if (core_rsp) begin
            rdata_q <= core_rdata;
         end
         if (state == RESP) begin
            flush_pend <= 1'b0;
         end else if (flush && (state == MISS_REQ || state == MISS_WAIT)) begin
            flush_pend <= 1'b1;
         end
      end
   end

   assign mem_addr   = mem_req ? (addr_q & LINE_MASK) : '0;
   assign core.gnt   = core_gnt;
   assign core.rsp   = core_rsp;
   assign core.rdata = core_rdata;

endmodule
